aes_hw_verify_top: RTL and testbench
====================================

Name: aes_hw_verify_top

Overview:
Self-checking, pure-hardware verification harness for the AES-128 encryption core. While `work` is high it loops over four built-in FIPS-197 / SP800-38A known-answer vectors. It runs each vector through one instance of the existing `aes128_core` and compares the ciphertext against the stored expected value. Two running counters report the number of encryptions attempted and the number that matched.

Parameters:
- CNT_W, 32: width of the `total` and `correct` counters.
- TIMEOUT, 1024: maximum cycles to wait for the core's `done` before declaring the vector failed.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- work  input  1  level enable; high = keep running vectors.
- total  output  CNT_W  number of completed (checked) vectors.
- correct  output  CNT_W  number of vectors whose ciphertext matched.

Behaviour:
- Clocking and reset (already decided): one clock `clk`; `rst_n` is an asynchronous, active-low reset.
- Reset values:
  - `total` = 0, `correct` = 0, FSM = IDLE, vector index = 0, timeout counter = 0.
  - Core `start` deasserted.
- Core instance interface: `aes128_core(clk, rst_n, start, key[127:0], din[127:0], dout[127:0], done)`.
  - `start` is a 1-cycle pulse.
  - `key` and `din` are held stable until `done`.
  - `done` is a 1-cycle pulse with `dout` valid in the same cycle.
  - Latency is variable and handled by the handshake.
- Vector ROM (index 0..3; key / plaintext / expected, hex):
  - 0: 000102030405060708090a0b0c0d0e0f / 00112233445566778899aabbccddeeff / 69c4e0d86a7b0430d8cdb78070b4c55a
  - 1: 2b7e151628aed2a6abf7158809cf4f3c / 3243f6a8885a308d313198a2e0370734 / 3925841d02dc09fbdc118597196a0b32
  - 2: 2b7e151628aed2a6abf7158809cf4f3c / 6bc1bee22e409f96e93d7e117393172a / 3ad77bb40d7a3660a89ecaf32466ef97
  - 3: 2b7e151628aed2a6abf7158809cf4f3c / ae2d8a571e03ac9c9eb76fac45af8e51 / f5d3d58503b9699de785895a96fdbaaf
- FSM states and transitions:
  - IDLE: if `work`=1, go to START.
  - START: assert `start` for exactly one cycle with ROM[index] on `key`/`din`; clear timeout counter; go to WAIT.
  - WAIT:
    - On `done`, register `dout`, go to CHECK.
    - Otherwise increment the timeout counter; when it reaches TIMEOUT-1, go to CHECK with the result marked failed.
  - CHECK (one cycle):
    - `total` += 1.
    - `correct` += 1 only if there was no timeout and `dout` equals expected[index].
    - index = (index+1) mod 4 (wraps 3 -> 0).
    - Next state is START if `work`=1, otherwise IDLE.
- `work` falling mid-transaction: the current vector still completes and is counted; then IDLE. Counters and index hold their values in IDLE. Re-asserting `work` resumes at the held index.
- Counters saturate at all-ones (no wrap). Both update in the same cycle, so `correct` <= `total` always.
- `total` and `correct` are registered outputs and change only in the CHECK cycle.
- A `done` pulse outside WAIT is ignored.
- Asserting reset mid-operation immediately returns every register to its reset value.

Test Plan:
- Reset held 1 µs, `work`=0 for 50 µs -> `total`=0, `correct`=0, `start` never pulses.
- `work`=1 with a functional core -> after each CHECK, `total` and `correct` increment together; after 8 vectors `total`=8, `correct`=8, index back at 0.
- Core model corrupting `dout` for vector 2 only -> after 4 vectors `total`=4, `correct`=3.
- Core model that never asserts `done` -> each vector takes TIMEOUT cycles; `total` increments, `correct` stays 0.
- Drop `work` while in WAIT on vector 1 -> vector 1 is counted, FSM goes to IDLE, counters stay frozen; re-raising `work` starts vector 2.
- Assert reset mid-WAIT with `total`=5 -> `total`=`correct`=0 immediately (asynchronously); after release with `work`=1, the run restarts at vector 0.

Source files
------------

// File: rtl/aes_hw_verify_top.sv
// ---------------------------------------------------------------------------
// aes_hw_verify_top
//
// Purpose: self-checking hardware harness around an iterative AES-128
// encryption core. While `work` is high it cycles through four built-in
// known-answer vectors (FIPS-197 / SP800-38A). It encrypts each one and
// compares the result with the stored ciphertext. Two saturating counters
// report how many vectors were checked and how many matched.
//
// This file holds two modules:
//   aes128_core        - iterative AES-128 encryptor, one round per clock.
//   aes_hw_verify_top  - vector sequencer, timeout watchdog and counters.
//
// Ports (aes_hw_verify_top):
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   work     in   1      level enable; high = keep running vectors
//   total    out  CNT_W  vectors checked (saturating)
//   correct  out  CNT_W  vectors whose ciphertext matched (saturating)
//
// Ports (aes128_core):
//   clk, rst_n     clock / asynchronous active-low reset
//   start   in  1    one-cycle request pulse; samples key and din
//   key     in  128  cipher key
//   din     in  128  plaintext
//   dout    out 128  ciphertext, valid in the cycle done is high
//   done    out 1    one-cycle completion pulse
//
// Core handshake: `start` is a single-cycle request. The requester keeps
// key/din stable until `done`. `done` is a single-cycle response with
// `dout` valid in that same cycle. There is no backpressure: a new `start`
// always (re)loads the core, even if it is busy.
// ---------------------------------------------------------------------------

module aes128_core (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] din,
    output logic [127:0] dout,
    output logic         done
);

    typedef enum logic {C_IDLE, C_RUN} core_state_e;

    core_state_e  state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] dout_q, dout_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic         done_q, done_d;
    logic [127:0] rk_next;
    logic [127:0] round_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box computed as multiplicative inverse (x^254) followed by the
    // affine transform, rather than a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // State byte i sits at bits [127-8i -: 8]; byte 4c+r is row r, column c.
    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] rk,
                                               input logic         last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c+r] = sb[4*((c+r)%4)+r];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) begin
                o[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                     xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return o ^ rk;
    endfunction

    // One step of the key schedule, done on the fly alongside each round.
    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    assign rk_next   = next_key(rk_q, rcon_q);
    assign round_out = aes_round(st_q, rk_next, round_q == 4'd10);

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rk_d    = rk_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        case (state_q)
            C_IDLE: ;
            C_RUN: begin
                st_d    = round_out;
                rk_d    = rk_next;
                rcon_d  = xtime(rcon_q);
                round_d = round_q + 4'd1;
                if (round_q == 4'd10) begin
                    dout_d  = round_out;
                    done_d  = 1'b1;
                    state_d = C_IDLE;
                end
            end
            default: state_d = C_IDLE;
        endcase
        // A request always wins, so a stale run never blocks a new vector.
        if (start) begin
            st_d    = din ^ key;
            rk_d    = key;
            rcon_d  = 8'h01;
            round_d = 4'd1;
            done_d  = 1'b0;
            state_d = C_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_IDLE;
            st_q    <= '0;
            rk_q    <= '0;
            dout_q  <= '0;
            rcon_q  <= 8'h01;
            round_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rk_q    <= rk_d;
            dout_q  <= dout_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign dout = dout_q;
    assign done = done_q;

endmodule

module aes_hw_verify_top #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             work,
    output logic [CNT_W-1:0] total,
    output logic [CNT_W-1:0] correct
);

    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_CHECK} state_e;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             tmo_fail_q, tmo_fail_d;
    logic [127:0]     res_q, res_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] correct_q, correct_d;

    logic             core_start;
    logic [127:0]     core_key;
    logic [127:0]     core_din;
    logic [127:0]     core_dout;
    logic             core_done;
    logic [127:0]     exp_ct;

    // Vector ROM entry: {key, plaintext, expected ciphertext}.
    function automatic logic [383:0] rom(input logic [1:0] i);
        logic [383:0] r;
        r = '0;
        case (i)
            2'd0: r = {128'h000102030405060708090a0b0c0d0e0f,
                       128'h00112233445566778899aabbccddeeff,
                       128'h69c4e0d86a7b0430d8cdb78070b4c55a};
            2'd1: r = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                       128'h3243f6a8885a308d313198a2e0370734,
                       128'h3925841d02dc09fbdc118597196a0b32};
            2'd2: r = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                       128'h6bc1bee22e409f96e93d7e117393172a,
                       128'h3ad77bb40d7a3660a89ecaf32466ef97};
            2'd3: r = {128'h2b7e151628aed2a6abf7158809cf4f3c,
                       128'hae2d8a571e03ac9c9eb76fac45af8e51,
                       128'hf5d3d58503b9699de785895a96fdbaaf};
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // idx_q only moves in CHECK, so key/din stay stable for the whole wait.
    assign {core_key, core_din, exp_ct} = rom(idx_q);
    assign core_start = (state_q == ST_START);

    aes128_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .start (core_start),
        .key   (core_key),
        .din   (core_din),
        .dout  (core_dout),
        .done  (core_done)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        tmo_fail_d = tmo_fail_q;
        res_d      = res_q;
        total_d    = total_q;
        correct_d  = correct_q;
        case (state_q)
            ST_IDLE: begin
                if (work) state_d = ST_START;
            end
            ST_START: begin
                tmo_d      = '0;
                tmo_fail_d = 1'b0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // done takes priority over a timeout landing in the same cycle
                if (core_done) begin
                    res_d   = core_dout;
                    state_d = ST_CHECK;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_fail_d = 1'b1;
                    state_d    = ST_CHECK;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_CHECK: begin
                total_d = sat_inc(total_q);
                if (!tmo_fail_q && (res_q == exp_ct)) correct_d = sat_inc(correct_q);
                idx_d   = idx_q + 2'd1;
                state_d = work ? ST_START : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            tmo_q      <= '0;
            tmo_fail_q <= 1'b0;
            res_q      <= '0;
            total_q    <= '0;
            correct_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            tmo_fail_q <= tmo_fail_d;
            res_q      <= res_d;
            total_q    <= total_d;
            correct_q  <= correct_d;
        end
    end

    assign total   = total_q;
    assign correct = correct_q;

endmodule

// File: tb/tb_aes_hw_verify_top.sv
// ---------------------------------------------------------------------------
// tb_aes_hw_verify_top
//
// Bench for aes_hw_verify_top. The reference model tracks which vector is
// in flight (index mod 4) and whether it should pass, given the fault the
// bench is injecting: ciphertext of vector 2 forced to zero, or core done
// held low. On every observed completion the model advances and the
// counters are compared. Directed phases cover idle-after-reset, plain
// runs, work dropped mid-vector, timeouts and asynchronous reset; a
// randomized phase toggles work and the fault with $urandom_range.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_aes_hw_verify_top;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 64;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             work  = 1'b0;
    logic [CNT_W-1:0] total;
    logic [CNT_W-1:0] correct;

    aes_hw_verify_top #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .work    (work),
        .total   (total),
        .correct (correct)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit               corrupt2    = 1'b0;  // force vector 2 ciphertext to zero
    bit               no_done     = 1'b0;  // core done held low
    bit               dout_forced = 1'b0;
    int               m_idx       = 0;     // vector the next completion belongs to
    int               m_total     = 0;
    int               m_correct   = 0;
    int               cyc         = 0;
    int               last_cyc    = 0;
    int               last_gap    = 0;
    int               start_pulses = 0;
    logic [CNT_W-1:0] prev_total  = '0;

    function automatic bit vector_passes(input int idx);
        return !no_done && !(corrupt2 && idx == 2);
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_idx      = 0;
            m_total    = 0;
            m_correct  = 0;
            prev_total = '0;
            last_cyc   = cyc;
        end else begin
            if (dut.core_start === 1'b1) start_pulses++;
            if (total !== prev_total) begin
                m_total++;
                if (vector_passes(m_idx)) m_correct++;
                m_idx    = (m_idx + 1) % 4;
                last_gap = cyc - last_cyc;
                last_cyc = cyc;
                check_eq("step_total", total, m_total);
                check_eq("step_correct", correct, m_correct);
                prev_total = total;
            end
        end
        if (corrupt2 && m_idx == 2 && !dout_forced) begin
            force dut.core_dout = 128'h0;
            dout_forced = 1'b1;
        end else if (!(corrupt2 && m_idx == 2) && dout_forced) begin
            release dut.core_dout;
            dout_forced = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_total(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (m_total < n && k < budget) begin
            tick();
            k++;
        end
        if (m_total < n) check_eq(tag, total, n);
    endtask

    // ---------------- stimulus ----------------
    int base;
    int c0;

    initial begin
        // reset held 1 us, then 50 us idle with work low
        rst_n = 1'b0;
        work  = 1'b0;
        repeat (100) tick();
        check_eq("rst_total", total, 0);
        check_eq("rst_correct", correct, 0);
        rst_n = 1'b1;
        repeat (5000) tick();
        check_eq("idle_total", total, 0);
        check_eq("idle_correct", correct, 0);
        check_eq("idle_start_pulses", start_pulses, 0);

        // functional core: 8 vectors, all correct
        work = 1'b1;
        wait_total(8, 8 * 40, "wait_run8");
        check_eq("run8_total", total, 8);
        check_eq("run8_correct", correct, 8);

        // vector 2 corrupted: next 4 vectors give 3 correct
        corrupt2 = 1'b1;
        wait_total(12, 4 * 40, "wait_corrupt4");
        check_eq("corrupt_total", total, 12);
        check_eq("corrupt_correct", correct, 11);

        // drop work while vector 1 is in WAIT
        wait_total(13, 40, "wait_vec0");
        repeat ($urandom_range(1, 8)) tick();
        work = 1'b0;
        repeat (200) tick();
        check_eq("drop_total", total, 14);
        check_eq("drop_correct", correct, 13);
        repeat ($urandom_range(50, 300)) tick();
        check_eq("frozen_total", total, 14);
        check_eq("frozen_correct", correct, 13);
        // resume: must start at vector 2, which is corrupted
        work = 1'b1;
        wait_total(15, 40, "wait_resume");
        check_eq("resume_total", total, 15);
        check_eq("resume_correct", correct, 13);

        // randomized work windows, fault toggled while idle
        for (int it = 0; it < 8; it++) begin
            work = 1'b0;
            repeat (100) tick();
            corrupt2 = 1'($urandom_range(0, 1));
            work = 1'b1;
            repeat ($urandom_range(5, 150)) tick();
            work = 1'b0;
            repeat (100) tick();
            check_eq("rand_total", total, m_total);
            check_eq("rand_correct", correct, m_correct);
        end

        // core never answers: every vector times out
        corrupt2 = 1'b0;
        repeat (5) tick();
        force dut.core_done = 1'b0;
        no_done = 1'b1;
        base = m_total;
        c0   = m_correct;
        work = 1'b1;
        wait_total(base + 3, 3 * (TIMEOUT + 20), "wait_timeouts");
        check_eq("tmo_gap_in_range", (last_gap >= TIMEOUT) && (last_gap <= TIMEOUT + 2), 1);
        check_eq("tmo_correct_run", correct, c0);
        work = 1'b0;
        repeat (3 * TIMEOUT) tick();
        check_eq("tmo_total", total, base + 4);
        check_eq("tmo_correct", correct, c0);
        release dut.core_done;
        no_done = 1'b0;

        // asynchronous reset in the middle of WAIT with total = 5
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        work  = 1'b1;
        wait_total(5, 5 * 40, "wait_five");
        check_eq("pre_reset_total", total, 5);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_total", total, 0);
        check_eq("async_rst_correct", correct, 0);
        corrupt2 = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        // restart at vector 0: vectors 0,1,2 with 2 corrupted
        wait_total(3, 3 * 40, "wait_restart");
        check_eq("restart_total", total, 3);
        check_eq("restart_correct", correct, 2);
        work = 1'b0;
        repeat (50) tick();

        $display("test done: total=%0d bad=%0d", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
